// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive controller and its bench.
// State codes are plain 3-bit constants so checkers and benches can
// compare against them directly; state_t wraps the same codes as an enum.
package uart_rx_pkg;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_START  = START,
        S_DATA   = DATA,
        S_PARITY = PARITY,
        S_STOP   = STOP,
        S_DONE   = DONE
    } state_t;

endpackage

// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART receive controller and its datapath
// (edge/bit counters, sampler, deserializer, start/parity/stop checkers).
//   master : datapath side - drives line, config, counter values, checker results
//   slave  : controller side - drives counter/sampler/checker enables, status
// state mirrors the controller's current state for observation only.
// There is no valid/ready handshake here: checker results are qualified by
// the controller itself at bit end (edge_cnt == prescale), and data_valid is
// a one-cycle pulse with no back-pressure.
interface uart_rx_fsm_if
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = 5
);
    logic               RX_IN;
    logic               PAR_EN;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] edge_cnt;
    logic [3:0]         bit_cnt;
    logic               strt_glitch;
    logic               par_err;
    logic               stp_err;

    logic               counter_en;
    logic               new_start;
    logic               dat_samp_en;
    logic               deser_en;
    logic               strt_chk_en;
    logic               par_chk_en;
    logic               stp_chk_en;
    logic               data_valid;
    logic               busy;
    state_t             state;

    modport master (
        output RX_IN, PAR_EN, prescale, edge_cnt, bit_cnt,
               strt_glitch, par_err, stp_err,
        input  counter_en, new_start, dat_samp_en, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en, data_valid, busy, state
    );

    modport slave (
        input  RX_IN, PAR_EN, prescale, edge_cnt, bit_cnt,
               strt_glitch, par_err, stp_err,
        output counter_en, new_start, dat_samp_en, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en, data_valid, busy, state
    );

endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive controller. Sequences one serial frame
// (start, DATA_WIDTH data bits, optional parity, stop) by enabling the
// external counters, sampler, deserializer and checkers at the right time.
// Ports:
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - uart_rx_fsm_if.slave: line/config/counter/checker inputs,
//          enable and status outputs (see the interface header)
// Flops: state register, sticky frame-error flag, data_valid register.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 5
) (
    input  logic           CLK,
    input  logic           RST,
    uart_rx_fsm_if.slave   bus
);

    localparam logic [PRESC_W:0] ONE = (PRESC_W+1)'(1);

    state_t state_q, state_d;
    logic   err_q, err_d;
    logic   dv_q, dv_d;

    // Comparisons are done one bit wider so prescale/2+1 never wraps.
    logic [PRESC_W:0] edge_x, presc_x, half_x;
    logic             bit_end, samp_win, last_data, line_low;

    assign edge_x    = {1'b0, bus.edge_cnt};
    assign presc_x   = {1'b0, bus.prescale};
    assign half_x    = {2'b00, bus.prescale[PRESC_W-1:1]};
    assign bit_end   = (edge_x == presc_x);
    assign samp_win  = (edge_x + ONE == half_x) || (edge_x == half_x) ||
                       (edge_x == half_x + ONE);
    assign last_data = (bus.bit_cnt == 4'(DATA_WIDTH));
    // A falling line is ignored while reset is held so no output can
    // rise during reset.
    assign line_low  = !bus.RX_IN && !RST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            dv_q    <= dv_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        err_d           = err_q;
        dv_d            = 1'b0;
        bus.counter_en  = 1'b0;
        bus.new_start   = 1'b0;
        bus.dat_samp_en = 1'b0;
        bus.deser_en    = 1'b0;
        bus.strt_chk_en = 1'b0;
        bus.par_chk_en  = 1'b0;
        bus.stp_chk_en  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (line_low) begin
                    state_d        = S_START;
                    bus.new_start  = 1'b1;
                    bus.counter_en = 1'b1;
                end
            end
            S_START: begin
                bus.counter_en  = 1'b1;
                bus.dat_samp_en = samp_win;
                if (bit_end) begin
                    bus.strt_chk_en = 1'b1;
                    state_d = bus.strt_glitch ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                bus.counter_en  = 1'b1;
                bus.dat_samp_en = samp_win;
                if (bit_end) begin
                    bus.deser_en = 1'b1;
                    // PAR_EN only matters at this one decision point.
                    if (last_data) begin
                        state_d = bus.PAR_EN ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                bus.counter_en  = 1'b1;
                bus.dat_samp_en = samp_win;
                if (bit_end) begin
                    bus.par_chk_en = 1'b1;
                    err_d   = err_q | bus.par_err;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                bus.counter_en  = 1'b1;
                bus.dat_samp_en = samp_win;
                if (bit_end) begin
                    bus.stp_chk_en = 1'b1;
                    err_d   = err_q | bus.stp_err;
                    state_d = S_DONE;
                    // Registered here so the pulse coincides with DONE.
                    dv_d    = !(err_q | bus.stp_err);
                end
            end
            S_DONE: begin
                bus.counter_en = 1'b1;
                err_d          = 1'b0;
                if (line_low) begin
                    state_d       = S_START;
                    bus.new_start = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.data_valid = dv_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.state      = state_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm. The bench plays the datapath: it drives the
// serial line, models the edge/bit counters from counter_en/new_start, and
// raises checker results at bit end. Expected data_valid cycles are queued
// when a frame is driven and popped when the pulse appears.
module tb_uart_rx_fsm;
    import uart_rx_pkg::*;

    localparam int DW = 8;
    localparam int PW = 5;

    logic CLK = 1'b0;
    logic RST;

    uart_rx_fsm_if #(.PRESC_W(PW)) bus ();

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESC_W(PW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int exp_q[$];
    int dv_seen     = 0;
    int deser_seen  = 0;
    int ns_seen     = 0;
    int ns_done     = 0;
    bit glitch_req  = 1'b0;
    bit par_req     = 1'b0;
    bit stp_req     = 1'b0;
    int par_cur     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] outs();
        return {bus.counter_en, bus.new_start, bus.dat_samp_en, bus.deser_en,
                bus.strt_chk_en, bus.par_chk_en, bus.stp_chk_en,
                bus.data_valid, bus.busy};
    endfunction

    task automatic monitor();
        int e, h;
        logic exp_samp;
        if (bus.data_valid) begin
            dv_seen++;
            if (exp_q.size() == 0) check("dv_unexpected", 32'd1, 32'd0);
            else check("dv_cycle", cyc, exp_q.pop_front());
        end
        if (bus.deser_en) deser_seen++;
        if (bus.new_start) begin
            ns_seen++;
            if (bus.state == S_DONE) ns_done++;
        end
        e = int'(bus.edge_cnt);
        h = int'(bus.prescale) / 2;
        exp_samp = (e == h - 1) || (e == h) || (e == h + 1);
        check("samp_window", bus.dat_samp_en, exp_samp);
    endtask

    // One clock cycle: checker results for this cycle, observe at negedge,
    // then advance the counter model after the rising edge.
    task automatic run_cycle();
        logic ns, ce, be;
        be = (bus.edge_cnt == bus.prescale);
        bus.strt_glitch = glitch_req && be && (bus.bit_cnt == 4'd0);
        bus.par_err     = par_req && be && (bus.bit_cnt == 4'(DW + 1));
        bus.stp_err     = stp_req && be && (bus.bit_cnt == 4'(DW + 1 + par_cur));
        @(negedge CLK);
        monitor();
        ns = bus.new_start;
        ce = bus.counter_en;
        @(posedge CLK);
        #1;
        cyc++;
        if (ns) begin
            bus.edge_cnt = PW'(1);
            bus.bit_cnt  = 4'd0;
        end else if (ce) begin
            if (bus.edge_cnt == bus.prescale) begin
                bus.edge_cnt = PW'(1);
                bus.bit_cnt  = bus.bit_cnt + 4'd1;
            end else begin
                bus.edge_cnt = bus.edge_cnt + PW'(1);
            end
        end else begin
            bus.edge_cnt = '0;
            bus.bit_cnt  = '0;
        end
    endtask

    task automatic idle(input int n);
        bus.RX_IN = 1'b1;
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_outs"}, outs(), 9'd0);
        check({tag, "_state"}, bus.state, IDLE);
    endtask

    task automatic apply_reset();
        #2;
        RST = 1'b1;
        #1;
        check("rst_async_outs", outs(), 9'd0);
        check("rst_async_state", bus.state, IDLE);
        bus.RX_IN    = 1'b1;
        bus.edge_cnt = '0;
        bus.bit_cnt  = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_hold_outs", outs(), 9'd0);
        RST = 1'b0;
    endtask

    // lag: cycles between the line falling and the controller seeing it.
    task automatic send_frame(input logic [7:0] data, input int par, input bit perr,
                              input bit serr, input int lag, input int rst_bit);
        logic [11:0] bits;
        int nbits, presc, fall;
        presc   = int'(bus.prescale);
        nbits   = DW + 2 + par;
        fall    = cyc;
        par_req = perr;
        stp_req = serr;
        glitch_req = 1'b0;
        par_cur = par;
        bus.PAR_EN = (par != 0);
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < DW; i++) bits[i+1] = data[i];
        if (par != 0) bits[DW+1] = ^data;
        for (int i = 0; i < nbits; i++) begin
            bus.RX_IN = bits[i];
            for (int j = 0; j < presc; j++) begin
                if (rst_bit >= 0 && bus.bit_cnt == 4'(rst_bit) && bus.edge_cnt == PW'(2)) begin
                    apply_reset();
                    return;
                end
                run_cycle();
                if (i == 0 && j == 0) check("busy_in_frame", bus.busy, 1'b1);
            end
        end
        if (!perr && !serr) exp_q.push_back(fall + lag + 1 + (DW + 2 + par) * presc);
    endtask

    initial begin
        int dv0, de0, ns0, nd0;
        RST             = 1'b1;
        bus.RX_IN       = 1'b1;
        bus.PAR_EN      = 1'b0;
        bus.prescale    = PW'(8);
        bus.edge_cnt    = '0;
        bus.bit_cnt     = '0;
        bus.strt_glitch = 1'b0;
        bus.par_err     = 1'b0;
        bus.stp_err     = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_quiet("reset");
        RST = 1'b0;
        idle(3);
        check_quiet("post_reset");

        // Single clean frame, no parity.
        dv0 = dv_seen; de0 = deser_seen;
        send_frame(8'hA5, 0, 1'b0, 1'b0, 0, -1);
        idle(4);
        check("a5_dv_count", dv_seen - dv0, 1);
        check("a5_deser_count", deser_seen - de0, DW);
        check_quiet("a5_after");

        // Start-bit glitch: line low for 3 cycles only.
        dv0 = dv_seen; de0 = deser_seen;
        par_req = 1'b0; stp_req = 1'b0; glitch_req = 1'b1;
        bus.RX_IN = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle();
        check("glitch_busy", bus.busy, 1'b1);
        idle(12);
        glitch_req = 1'b0;
        check("glitch_dv_count", dv_seen - dv0, 0);
        check("glitch_deser_count", deser_seen - de0, 0);
        check_quiet("glitch_after");

        // Parity error at prescale 16, then a clean parity frame.
        bus.prescale = PW'(16);
        dv0 = dv_seen;
        send_frame(8'h5A, 1, 1'b1, 1'b0, 0, -1);
        idle(4);
        check("perr_dv_count", dv_seen - dv0, 0);
        check_quiet("perr_after");
        dv0 = dv_seen; de0 = deser_seen;
        send_frame(8'h96, 1, 1'b0, 1'b0, 0, -1);
        idle(4);
        check("par_ok_dv_count", dv_seen - dv0, 1);
        check("par_ok_deser_count", deser_seen - de0, DW);

        // Back-to-back frames: second start bit right after the first stop.
        bus.prescale = PW'(8);
        idle(2);
        dv0 = dv_seen; de0 = deser_seen; ns0 = ns_seen; nd0 = ns_done;
        send_frame(8'h3C, 0, 1'b0, 1'b0, 0, -1);
        send_frame(8'hC3, 0, 1'b0, 1'b0, 1, -1);
        idle(4);
        check("b2b_dv_count", dv_seen - dv0, 2);
        check("b2b_deser_count", deser_seen - de0, 2 * DW);
        check("b2b_new_start", ns_seen - ns0, 2);
        check("b2b_ns_in_done", ns_done - nd0, 1);
        check_quiet("b2b_after");

        // Reset in the middle of the data bits, then a clean frame.
        dv0 = dv_seen;
        send_frame(8'hA5, 0, 1'b0, 1'b0, 0, 4);
        idle(4);
        check("rst_frame_dv_count", dv_seen - dv0, 0);
        check_quiet("rst_after");
        dv0 = dv_seen;
        send_frame(8'h69, 0, 1'b0, 1'b0, 0, -1);
        idle(4);
        check("post_rst_dv_count", dv_seen - dv0, 1);

        // Stop-bit error.
        dv0 = dv_seen;
        send_frame(8'h0F, 0, 1'b0, 1'b1, 0, -1);
        idle(4);
        stp_req = 1'b0;
        check("serr_dv_count", dv_seen - dv0, 0);
        check_quiet("serr_after");

        check("sb_pending", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter PRESC_W, default 5, width of prescale and edge_cnt.
REQ-003 SHALL have port CLK  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port RX_IN  input  1  serial line; idle high.
REQ-006 SHALL have port PAR_EN  input  1  frame carries a parity bit when 1.
REQ-007 SHALL have port prescale  input  PRESC_W  clock cycles per bit (8..31), held stable while busy.
REQ-008 SHALL have port edge_cnt  input  PRESC_W  edge counter value, 1..prescale within each bit.
REQ-009 SHALL have port bit_cnt  input  4  bit counter value: 0 start, 1..DATA_WIDTH data, then parity/stop.
REQ-010 SHALL have ports strt_glitch, par_err, stp_err  input  1 each  checker results, valid when edge_cnt==prescale.
REQ-011 SHALL have ports counter_en, new_start  output  1 each  edge/bit counter controls.
REQ-012 SHALL have ports dat_samp_en, deser_en  output  1 each  sampler and deserializer enables.
REQ-013 SHALL have ports strt_chk_en, par_chk_en, stp_chk_en  output  1 each  checker enables.
REQ-014 SHALL have ports data_valid, busy  output  1 each  frame-accepted pulse; not in IDLE.

Function
REQ-015 SHALL implement a registered FSM with states IDLE, START, DATA, PARITY, STOP, DONE; "bit end" means edge_cnt==prescale.
REQ-016 IDLE: RX_IN==0 -> START, with new_start=1 and counter_en=1 combinationally in that cycle; otherwise remain.
REQ-017 START: strt_chk_en=1 at bit end; strt_glitch=1 -> IDLE (no data_valid), else -> DATA.
REQ-018 DATA: deser_en=1 at bit end; bit end with bit_cnt==DATA_WIDTH -> PARITY if PAR_EN else STOP.
REQ-019 PARITY: par_chk_en=1 at bit end; bit end -> STOP; par_err latched into a sticky error flag.
REQ-020 STOP: stp_chk_en=1 at bit end; bit end -> DONE; stp_err latched into the sticky error flag.
REQ-021 DONE lasts one cycle: data_valid=1 iff sticky error flag is 0; sticky flag cleared; RX_IN==0 -> START with new_start=1, else IDLE.
REQ-022 counter_en SHALL be 1 in START, DATA, PARITY, STOP, DONE and in the IDLE->START cycle; 0 otherwise.
REQ-023 dat_samp_en SHALL be 1 in START/DATA/PARITY/STOP when edge_cnt is prescale/2-1, prescale/2 or prescale/2+1 (integer divide).
REQ-024 data_valid SHALL be a registered single-cycle pulse asserted the cycle after DONE is entered; all other outputs decoded from state, edge_cnt, RX_IN.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 PAR_EN SHALL be sampled only at the DATA exit decision; changes elsewhere mid-frame have no effect on the current frame.
REQ-027 Comparisons SHALL be zero-extended to PRESC_W+1 bits; no wrap on prescale/2+1.

Reset
REQ-028 RST=1 SHALL immediately force state IDLE, sticky error flag 0, data_valid 0, regardless of CLK.
REQ-029 While RST=1 and after release, every output SHALL be 0 until RX_IN falls; reset mid-frame discards the frame with no data_valid.

Structure
REQ-030 State encoding (3-bit localparams IDLE..DONE) SHALL reside in shared package uart_rx_pkg for reuse by the bench.
REQ-031 Block SHALL be a single module with no sub-modules; state register, sticky flag and data_valid register are its only flops.

Verification
REQ-032 prescale=8, PAR_EN=0, frame 0xA5 with valid stop -> data_valid pulse exactly once, 81 cycles after RX_IN falls; busy low after.
REQ-033 prescale=8, RX_IN low 3 cycles, strt_glitch=1 at start bit end -> IDLE, no data_valid, deser_en never asserted.
REQ-034 prescale=16, PAR_EN=1, par_err=1 at parity bit end -> STOP then DONE, data_valid stays 0, next clean frame gives data_valid.
REQ-035 prescale=8, two back-to-back frames (0x3C, 0xC3), start bit immediately after stop -> DONE->START directly, new_start=1 in DONE, two data_valid pulses.
REQ-036 RST asserted at bit_cnt==4 in DATA -> all outputs 0 asynchronously, state IDLE, no data_valid; next frame received correctly.
REQ-037 prescale=8, stp_err=1 at stop bit end -> data_valid 0; dat_samp_en asserted exactly on edge_cnt 3,4,5 of every bit.
